// File: rtl/yarp_pkg.sv
// Shared types and constants for the yarp core.
// Holds the machine word width, the fetch queue entry layout and its
// default depth, plus a small helper for the misalignment flag.
package yarp_pkg;

    localparam int XLEN = 32;

    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misalign;
    } fetch_entry_t;

    // An instruction word is misaligned when its PC is not word aligned.
    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return |pc[1:0];
    endfunction

endpackage

// File: rtl/yarp_fetch_queue.sv
// Instruction fetch queue between instruction memory and decode.
// Buffers {pc, instr, misalign} entries in registers, presents the head
// entry combinationally to decode, and empties on a redirect flush.
// Optional macro YARP_FETCH_QUEUE_BYPASS_EN: when the queue is empty the
// incoming word is forwarded straight to decode in the same cycle and is
// only written into storage if decode does not take it.
module yarp_fetch_queue
    import yarp_pkg::*;
#(
    parameter int  DEPTH = FETCH_QUEUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_valid_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    input  logic [XLEN-1:0] fetch_instr_i,
    output logic            fetch_ready_o,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [XLEN-1:0] dec_instr_o,
    output logic            dec_misalign_o,
    input  logic            flush_i,
    output logic [PTR_W:0]  count_o
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] wr_ptr;

    fetch_entry_t entries [DEPTH];
    fetch_entry_t wr_entry;
    fetch_entry_t head_entry;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass_take;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[PTR_W-1:0] == wr_ptr[PTR_W-1:0]) &&
                   (rd_ptr[PTR_W] != wr_ptr[PTR_W]);

    assign count_o = wr_ptr - rd_ptr;

    // Ready depends only on stored state and flush, never on decode.
    assign fetch_ready_o = !full && !flush_i;

    assign wr_entry = '{pc:       fetch_pc_i,
                        instr:    fetch_instr_i,
                        misalign: pc_misaligned(fetch_pc_i)};

`ifdef YARP_FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming word; decode taking it skips the write.
    assign bypass_take = empty && !flush_i && fetch_valid_i && dec_ready_i;
    assign dec_valid_o = !flush_i && (empty ? fetch_valid_i : 1'b1);
    assign head_entry  = empty ? wr_entry : entries[rd_ptr[PTR_W-1:0]];
`else
    assign bypass_take = 1'b0;
    assign dec_valid_o = !empty && !flush_i;
    assign head_entry  = entries[rd_ptr[PTR_W-1:0]];
`endif

    assign push = fetch_valid_i && fetch_ready_o && !bypass_take;
    assign pop  = dec_valid_o && dec_ready_i && !empty;

    // Decode outputs are forced to zero whenever nothing valid is presented.
    always_comb begin
        dec_pc_o       = '0;
        dec_instr_o    = '0;
        dec_misalign_o = 1'b0;
        if (dec_valid_o) begin
            dec_pc_o       = head_entry.pc;
            dec_instr_o    = head_entry.instr;
            dec_misalign_o = head_entry.misalign;
        end
    end

    // Entry storage is written on push only and deliberately has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr[PTR_W-1:0]] <= wr_entry;
        end
    end

    // Pointer update: flush rewinds both pointers, otherwise advance on push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_yarp_fetch_queue.sv
// Self-checking bench for yarp_fetch_queue.
// A scoreboard queue of expected entries is filled as words are accepted
// and consumed in order as decode takes them. Works for both builds of
// the YARP_FETCH_QUEUE_BYPASS_EN option.
module tb_yarp_fetch_queue;
    import yarp_pkg::*;

    localparam int DEPTH = 4;

    logic            clk;
    logic            reset_n;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_instr;
    logic            fetch_ready;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_instr;
    logic            dec_misalign;
    logic            flush;
    logic [2:0]      count;

    fetch_entry_t sb [$];
    fetch_entry_t exp_e;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef YARP_FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    yarp_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_valid_i  (fetch_valid),
        .fetch_pc_i     (fetch_pc),
        .fetch_instr_i  (fetch_instr),
        .fetch_ready_o  (fetch_ready),
        .dec_valid_o    (dec_valid),
        .dec_ready_i    (dec_ready),
        .dec_pc_o       (dec_pc),
        .dec_instr_o    (dec_instr),
        .dec_misalign_o (dec_misalign),
        .flush_i        (flush),
        .count_o        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [XLEN-1:0] instr_for(input logic [XLEN-1:0] pc);
        return 32'h0000_0013 ^ (pc << 8);
    endfunction

    // Advance one clock; the reference model decides what the queue accepts.
    task automatic tick();
        bit take;
        bit do_pop;
        bit do_push;
        fetch_entry_t e;
        take    = BYPASS && fetch_valid && !flush && dec_ready && (sb.size() == 0);
        do_pop  = !flush && dec_ready && (sb.size() > 0);
        do_push = fetch_valid && !flush && (sb.size() < DEPTH) && !take;
        e.pc       = fetch_pc;
        e.instr    = fetch_instr;
        e.misalign = (fetch_pc[1:0] != 2'b00);
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic set_push(input logic [XLEN-1:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_instr = instr_for(pc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
        dec_ready = 1'b0; flush = 1'b0;
        #2;
        n_checks++;
        if (dec_valid !== 1'b0 || count !== 3'd0 || dec_pc !== '0 || dec_instr !== '0 || dec_misalign !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: valid=%b count=%0d pc=%h instr=%h mis=%b, required 0/0/0/0/0",
                     dec_valid, count, dec_pc, dec_instr, dec_misalign);
        end
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        #1;
        n_checks++;
        if (fetch_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %b, required 1", fetch_ready);
        end
    endtask

    task automatic test_first_push();
        set_push(32'h0);
        fetch_instr = 32'h0000_0013;
        dec_ready = 1'b1;
        #1;
        n_checks++;
        if (dec_valid !== BYPASS) begin
            n_fail++;
            $display("[TB] FAIL first_same_cycle_valid: got %b, required %b", dec_valid, BYPASS);
        end
        if (BYPASS) begin
            n_checks++;
            if (dec_pc !== 32'h0 || dec_instr !== 32'h0000_0013) begin
                n_fail++;
                $display("[TB] FAIL first_bypass_data: pc=%h instr=%h, required 0/00000013", dec_pc, dec_instr);
            end
        end
        tick();
        fetch_valid = 1'b0;
        #1;
        if (BYPASS) begin
            n_checks++;
            if (count !== 3'd0 || dec_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL first_bypass_after: count=%0d valid=%b, required 0/0", count, dec_valid);
            end
        end else begin
            n_checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0000_0013 || count !== 3'd1) begin
                n_fail++;
                $display("[TB] FAIL first_visible: valid=%b pc=%h instr=%h count=%0d, required 1/0/00000013/1",
                         dec_valid, dec_pc, dec_instr, count);
            end
            tick();
            #1;
            n_checks++;
            if (count !== 3'd0 || dec_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL first_consumed: count=%0d valid=%b, required 0/0", count, dec_valid);
            end
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        dec_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(32'(4 * i));
            tick();
        end
        set_push(32'h10);
        #1;
        n_checks++;
        if (count !== 3'd4 || fetch_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fill_full: count=%0d ready=%b, required 4/0", count, fetch_ready);
        end
        tick();
        fetch_valid = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            exp_e = sb[0];
            n_checks++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_e.pc || dec_pc !== 32'(4 * i) || dec_instr !== exp_e.instr) begin
                n_fail++;
                $display("[TB] FAIL drain_order[%0d]: valid=%b pc=%h instr=%h, required 1/%h/%h",
                         i, dec_valid, dec_pc, dec_instr, exp_e.pc, exp_e.instr);
            end
            tick();
        end
        #1;
        n_checks++;
        if (dec_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL drain_empty: valid=%b count=%0d, required 0/0 (dropped word leaked?)", dec_valid, count);
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        dec_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(32'h200 + 32'(4 * i));
            tick();
        end
        set_push(32'h40);
        dec_ready = 1'b1;
        #1;
        exp_e = sb[0];
        n_checks++;
        if (fetch_ready !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== exp_e.pc) begin
            n_fail++;
            $display("[TB] FAIL full_pushpop_cycle: ready=%b valid=%b pc=%h, required 0/1/%h",
                     fetch_ready, dec_valid, dec_pc, exp_e.pc);
        end
        tick();
        fetch_valid = 1'b0;
        dec_ready = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd3 || fetch_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL full_pushpop_after: count=%0d ready=%b, required 3/1", count, fetch_ready);
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_e = sb[0];
            n_checks++;
            if (dec_pc !== exp_e.pc || dec_pc === 32'h40) begin
                n_fail++;
                $display("[TB] FAIL full_remaining[%0d]: pc=%h, required %h", i, dec_pc, exp_e.pc);
            end
            tick();
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        dec_ready = 1'b0;
        set_push(32'h0); tick();
        set_push(32'h4); tick();
        dec_ready = 1'b1;
        for (int i = 2; i < 10; i++) begin
            set_push(32'(4 * i));
            #1;
            exp_e = sb[0];
            n_checks++;
            if (dec_pc !== exp_e.pc || dec_pc !== 32'(4 * (i - 2)) || dec_instr !== exp_e.instr || count !== 3'd2) begin
                n_fail++;
                $display("[TB] FAIL b2b[%0d]: pc=%h instr=%h count=%0d, required %h/%h/2",
                         i, dec_pc, dec_instr, count, exp_e.pc, exp_e.instr);
            end
            tick();
        end
        fetch_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            exp_e = sb[0];
            n_checks++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_e.pc || dec_pc !== 32'(32'h20 + 4 * i)) begin
                n_fail++;
                $display("[TB] FAIL b2b_tail[%0d]: valid=%b pc=%h, required 1/%h", i, dec_valid, dec_pc, exp_e.pc);
            end
            tick();
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_flush();
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(32'h300 + 32'(4 * i));
            tick();
        end
        set_push(32'h400);
        dec_ready = 1'b1;
        flush = 1'b1;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0 || dec_valid !== 1'b0 || dec_pc !== '0) begin
            n_fail++;
            $display("[TB] FAIL flush_cycle: ready=%b valid=%b pc=%h, required 0/0/0", fetch_ready, dec_valid, dec_pc);
        end
        tick();
        flush = 1'b0;
        fetch_valid = 1'b0;
        dec_ready = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || dec_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_after: count=%0d valid=%b ready=%b, required 0/0/1", count, dec_valid, fetch_ready);
        end
        set_push(32'h500);
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        fetch_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_held: count=%0d valid=%b, required 0/0", count, dec_valid);
        end
    endtask

    task automatic test_misalign_and_reset();
        logic [XLEN-1:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h102; pcs[2] = 32'h104;
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(pcs[i]);
            tick();
        end
        fetch_valid = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_e = sb[0];
            n_checks++;
            if (dec_pc !== exp_e.pc || dec_misalign !== exp_e.misalign || dec_misalign !== (i == 1)) begin
                n_fail++;
                $display("[TB] FAIL misalign[%0d]: pc=%h mis=%b, required %h/%b", i, dec_pc, dec_misalign, exp_e.pc, exp_e.misalign);
            end
            tick();
        end
        dec_ready = 1'b0;
        set_push(32'h600); tick();
        set_push(32'h604); tick();
        fetch_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd2 || dec_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset: count=%0d valid=%b, required 2/1", count, dec_valid);
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dec_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: valid=%b count=%0d, required 0/0", dec_valid, count);
        end
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill_drain();
        test_full_push_pop();
        test_back_to_back();
        test_flush();
        test_misalign_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/yarp_fetch_queue.md
Name: yarp_fetch_queue

Overview:
- Small instruction fetch queue between the instruction-memory stage and decode.
- Captures each returned instruction word together with its PC and a misalignment flag, and decouples memory return timing from decode back-pressure.
- Flushes on control-flow redirect.
- Entries are stored in registers; read-out is combinational from the head entry.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), index width; derived, not overridable.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- fetch_valid_i  in  1  instruction word valid from instruction-memory stage
- fetch_pc_i  in  XLEN  PC of the word
- fetch_instr_i  in  XLEN  instruction word
- fetch_ready_o  out  1  queue accepts a push this cycle
- dec_valid_o  out  1  head entry valid toward decode
- dec_ready_i  in  1  decode consumes head this cycle
- dec_pc_o  out  XLEN  head PC
- dec_instr_o  out  XLEN  head instruction
- dec_misalign_o  out  1  head PC[1:0] != 0
- flush_i  in  1  redirect; discard all entries
- count_o  out  PTR_W+1  occupancy, 0..DEPTH

Behaviour:
- Reset (async, reset_n low):
  - rd/wr pointers = 0, count = 0.
  - All outputs become valid/deterministic immediately: fetch_ready_o=1 (reset_n released, flush_i low), dec_valid_o=0, dec_pc_o=0, dec_instr_o=0, dec_misalign_o=0, count_o=0.
  - Entry storage is not reset.
- Pointers are PTR_W+1 bits with a wrap bit.
  - empty = (rd==wr); full = index bits equal and wrap bits differ.
  - count_o = wr - rd, modulo 2^(PTR_W+1).
- fetch_ready_o = !full && !flush_i. Combinational, from registered state and flush_i only; no dependency on dec_ready_i.
- push = fetch_valid_i && fetch_ready_o.
  - Writes {fetch_pc_i, fetch_instr_i, |fetch_pc_i[1:0]} at wr index; wr increments at clock edge.
- dec_valid_o = !empty && !flush_i.
  - When dec_valid_o=0, dec_pc_o/dec_instr_o/dec_misalign_o are driven to 0.
- pop = dec_valid_o && dec_ready_i; rd increments at clock edge.
- Latency: word pushed in cycle N is visible on dec_* in cycle N+1 at earliest.
- Simultaneous push and pop:
  - Allowed whenever not full and not empty; count unchanged.
  - When full, push is blocked; the pop still proceeds and ready rises next cycle.
  - No same-cycle pass-through when full.
- Wrap-around: index bits wrap naturally at DEPTH; the wrap bit toggles.
- flush_i=1:
  - fetch_ready_o=0 and dec_valid_o=0 that cycle, so no push or pop.
  - At the edge, rd and wr load 0 and count becomes 0.
  - Next cycle the queue is empty and ready.
  - Flush is held-safe: multi-cycle flush keeps the queue empty.
- fetch_valid_i while fetch_ready_o=0: word is dropped.
  - Upstream must hold or re-request; the queue keeps no memory of it.
- Misalignment is only flagged and carried with the entry; the queue does not trap or alter the word.

Optional Feature:
- Macro YARP_FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When empty and not flushing, dec_valid_o = fetch_valid_i; dec_* are driven directly from fetch_* (misalign computed combinationally).
  - If dec_ready_i is also 1, the word is consumed without being written and the pointers and count are unchanged.
  - If dec_ready_i is 0, the word is pushed normally.
  - Zero-cycle latency in the empty case.
- Undefined: behaviour exactly as above; minimum latency 1 cycle.

Decomposition:
- yarp_pkg gains:
  - typedef struct packed fetch_entry_t {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr; logic misalign;}
  - localparam FETCH_QUEUE_DEPTH = 4
- XLEN comes from yarp_pkg.
- No sub-module: pointer logic and storage are small enough to live in one module.

Test Plan:
- Reset, then push PC=0x0 instr=0x00000013 in cycle 1 → dec_valid_o=1 in cycle 2 with dec_pc_o=0x0, dec_instr_o=0x00000013, count_o=1; bypass build: visible in cycle 1, count_o stays 0 when dec_ready_i=1.
- dec_ready_i=0, push 0x0, 0x4, 0x8, 0xC → count_o=4, fetch_ready_o=0. A fifth push (0x10) is dropped. Drain yields 0x0, 0x4, 0x8, 0xC in order, then dec_valid_o=0.
- Full queue, push and pop asserted in the same cycle → pop occurs, push blocked, count_o=3, fetch_ready_o=1 next cycle.
- Continuous push and pop for 10 words (PC 0x0..0x24) with count held at 2 → output order exact across pointer wrap, count_o constant 2.
- Three entries held, flush_i=1 with fetch_valid_i=1 and dec_ready_i=1 → no pop, no push; next cycle count_o=0, dec_valid_o=0, fetch_ready_o=1.
- Push PC=0x102 → dec_misalign_o=1 on that entry only. Assert reset_n=0 mid-stream with 2 entries → dec_valid_o=0 and count_o=0 immediately, without waiting for a clock edge.
